seg_scan_controller: RTL



---
 rtl/seg_scan_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan controller: shares one hex decoder across NUM_DIGITS
// common-anode digits, with per-slot blanking guard, tear-free updates and leading-zero blanking.
module seg_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    update,
    input  logic                    lz_blank_en,
    output logic [3:0]              digit_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nx;
    logic [VAL_W-1:0]   staging;
    logic [VAL_W-1:0]   shadow;
    logic [VAL_W-1:0]   shadow_nx;
    logic               pending;
    logic               pending_nx;
    logic               frame_load;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] digit_sel_nx;
    logic [3:0]         digit_out_nx;
    logic               frame_done_nx;

    // Digit i is blanked when it and every more-significant digit are zero (digit 0 never).
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (shadow[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_blank_en & zero_run & (i > 0);
        end
    end

    // Next-state, shadow load and next output values.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        idx_nx        = idx;
        frame_load    = 1'b0;
        shadow_nx     = shadow;
        pending_nx    = pending;
        digit_sel_nx  = '1;
        digit_out_nx  = 4'hF;
        frame_done_nx = 1'b0;

        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx   = BLANK;
                    cnt_nx     = '0;
                    idx_nx     = '0;
                    frame_load = 1'b1;
                end
                BLANK: begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == CNT_BLANK_LAST) begin
                        state_nx = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_nx   = BLANK;
                        cnt_nx     = '0;
                        frame_load = (idx == IDX_LAST);
                        idx_nx     = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end

        // A strobe coinciding with the frame start bypasses staging.
        if (frame_load) begin
            if (update) begin
                shadow_nx = value;
            end else if (pending) begin
                shadow_nx = staging;
            end
            pending_nx = 1'b0;
        end else if (update) begin
            pending_nx = 1'b1;
        end

        // SHOW is never entered on a shadow-load edge, so the current shadow is the one displayed.
        if (state_nx == SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_nx == IDX_W'(i)) begin
                    digit_sel_nx[i] = 1'b0;
                    digit_out_nx    = lz_mask[i] ? 4'hF : shadow[4*i +: 4];
                end
            end
            frame_done_nx = (idx_nx == IDX_LAST) && (cnt_nx == CNT_LAST);
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            staging    <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            digit_sel  <= '1;
            digit_out  <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            shadow     <= shadow_nx;
            pending    <= pending_nx;
            digit_sel  <= digit_sel_nx;
            digit_out  <= digit_out_nx;
            frame_done <= frame_done_nx;
            if (update) begin
                staging <= value;
            end
        end
    end

endmodule
